// File: rtl/time_set_ctrl_if.sv
// Button/tick inputs and display-side outputs of the timekeeping controller.
// Both are grouped in one bundle with master (stimulus) and slave (controller) views.
interface time_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic [1:0] mode;
  logic [2:0] blank;
  logic       div_sync;

  modport master (
    output tick_1hz, btn_mode, btn_inc, btn_dec,
    input  hh_bcd, mm_bcd, ss_bcd, mode, blank, div_sync
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, btn_dec,
    output hh_bcd, mm_bcd, ss_bcd, mode, blank, div_sync
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Millennium Clock time-of-day keeper with a button-driven set mode.
// Fields are held directly in BCD so every output is a plain register.
module time_set_ctrl #(
  parameter bit HOURS_24 = 1'b1
) (
  input logic           clk_50Mhz,
  input logic           rst,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  localparam logic [7:0] HH_MAX = HOURS_24 ? 8'h23 : 8'h12;
  localparam logic [7:0] HH_MIN = HOURS_24 ? 8'h00 : 8'h01;
  localparam logic [7:0] HH_RST = HOURS_24 ? 8'h00 : 8'h12;

  state_t     state_q, state_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       phase_q, phase_d;
  logic [2:0] blank_q, blank_d;
  logic       div_sync_q, div_sync_d;
  logic       step_up, step_dn;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] hi,
                                         input logic [7:0] lo);
    if (v == hi)            return lo;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] hi,
                                         input logic [7:0] lo);
    if (v == lo)             return hi;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      state_q    <= RUN;
      hh_q       <= HH_RST;
      mm_q       <= '0;
      ss_q       <= '0;
      phase_q    <= 1'b0;
      blank_q    <= '0;
      div_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      phase_q    <= phase_d;
      blank_q    <= blank_d;
      div_sync_q <= div_sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    phase_d    = phase_q;
    div_sync_d = 1'b0;
    blank_d    = '0;
    step_up    = bus.btn_inc & ~bus.btn_dec;
    step_dn    = bus.btn_dec & ~bus.btn_inc;

    if (state_q == RUN) begin
      // Tick and mode in the same cycle: the tick still lands before freezing.
      if (bus.tick_1hz) begin
        ss_d = bcd_inc(ss_q, 8'h59, 8'h00);
        if (ss_q == 8'h59) begin
          mm_d = bcd_inc(mm_q, 8'h59, 8'h00);
          if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, HH_MAX, HH_MIN);
        end
      end
      if (bus.btn_mode) begin
        state_d = SET_HH;
        phase_d = 1'b0;
      end
    end else if (bus.btn_mode) begin
      phase_d = 1'b0;
      case (state_q)
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_SS;
        default: begin
          state_d    = RUN;
          ss_d       = '0;
          div_sync_d = 1'b1;
        end
      endcase
    end else if (step_up | step_dn) begin
      phase_d = 1'b0;
      case (state_q)
        SET_HH:  hh_d = step_up ? bcd_inc(hh_q, HH_MAX, HH_MIN) : bcd_dec(hh_q, HH_MAX, HH_MIN);
        SET_MM:  mm_d = step_up ? bcd_inc(mm_q, 8'h59, 8'h00) : bcd_dec(mm_q, 8'h59, 8'h00);
        default: ss_d = step_up ? bcd_inc(ss_q, 8'h59, 8'h00) : bcd_dec(ss_q, 8'h59, 8'h00);
      endcase
    end else if (bus.tick_1hz) begin
      phase_d = ~phase_q;
    end

    case (state_d)
      SET_HH:  blank_d = {phase_d, 2'b00};
      SET_MM:  blank_d = {1'b0, phase_d, 1'b0};
      SET_SS:  blank_d = {2'b00, phase_d};
      default: blank_d = '0;
    endcase
  end

  assign bus.hh_bcd   = hh_q;
  assign bus.mm_bcd   = mm_q;
  assign bus.ss_bcd   = ss_q;
  assign bus.mode     = state_q;
  assign bus.blank    = blank_q;
  assign bus.div_sync = div_sync_q;

endmodule
